// File: rtl/rd_return_1_to_9.sv
// Return path for a 9-requester shared register-file read port: pipelines the one-hot requester
// tag across the read latency and strobes rd_data to the owning port. Optional: RD_RETURN_MULTI_ERR_EN.
module rd_return_1_to_9 #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             port0_rd_en,
  input  logic             port1_rd_en,
  input  logic             port2_rd_en,
  input  logic             port3_rd_en,
  input  logic             port4_rd_en,
  input  logic             port5_rd_en,
  input  logic             port6_rd_en,
  input  logic             port7_rd_en,
  input  logic             port8_rd_en,
  input  logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] port0_rd_data,
  output logic [WIDTH-1:0] port1_rd_data,
  output logic [WIDTH-1:0] port2_rd_data,
  output logic [WIDTH-1:0] port3_rd_data,
  output logic [WIDTH-1:0] port4_rd_data,
  output logic [WIDTH-1:0] port5_rd_data,
  output logic [WIDTH-1:0] port6_rd_data,
  output logic [WIDTH-1:0] port7_rd_data,
  output logic [WIDTH-1:0] port8_rd_data,
  output logic             port0_rd_valid,
  output logic             port1_rd_valid,
  output logic             port2_rd_valid,
  output logic             port3_rd_valid,
  output logic             port4_rd_valid,
  output logic             port5_rd_valid,
  output logic             port6_rd_valid,
  output logic             port7_rd_valid,
  output logic             port8_rd_valid,
  output logic             multi_rd_err
);

  localparam int NPORT = 9;

  logic [NPORT-1:0] req_en;
  logic [3:0]       req_cnt;
  logic [3:0]       req_idx;
  logic             tag_vld;

  logic [LATENCY-1:0] stg_vld;
  logic [3:0]         stg_idx [LATENCY];

  logic [NPORT-1:0] valid_q;
  logic [WIDTH-1:0] data_q [NPORT];

  assign req_en = {port8_rd_en, port7_rd_en, port6_rd_en, port5_rd_en, port4_rd_en,
                   port3_rd_en, port2_rd_en, port1_rd_en, port0_rd_en};

  // idx only ever takes 0..8; a multi-enable cycle yields an invalid tag
  always_comb begin
    req_cnt = '0;
    req_idx = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (req_en[i]) begin
        req_cnt = req_cnt + 4'd1;
        req_idx = 4'(i);
      end
    end
  end

  assign tag_vld = (req_cnt == 4'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_vld <= '0;
      for (int i = 0; i < LATENCY; i++) stg_idx[i] <= '0;
    end else begin
      stg_vld[0] <= tag_vld;
      stg_idx[0] <= req_idx;
      for (int i = 1; i < LATENCY; i++) begin
        stg_vld[i] <= stg_vld[i-1];
        stg_idx[i] <= stg_idx[i-1];
      end
    end
  end

  // Returned data is held per port until that port is returned to again
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int p = 0; p < NPORT; p++) data_q[p] <= '0;
    end else begin
      valid_q <= '0;
      if (stg_vld[LATENCY-1]) begin
        for (int p = 0; p < NPORT; p++) begin
          if (stg_idx[LATENCY-1] == 4'(p)) begin
            valid_q[p] <= 1'b1;
            data_q[p]  <= rd_data;
          end
        end
      end
    end
  end

`ifdef RD_RETURN_MULTI_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (req_cnt > 4'd1) begin
      err_q <= 1'b1;
    end
  end

  assign multi_rd_err = err_q;
`else
  assign multi_rd_err = 1'b0;
`endif

  assign port0_rd_data  = data_q[0];
  assign port1_rd_data  = data_q[1];
  assign port2_rd_data  = data_q[2];
  assign port3_rd_data  = data_q[3];
  assign port4_rd_data  = data_q[4];
  assign port5_rd_data  = data_q[5];
  assign port6_rd_data  = data_q[6];
  assign port7_rd_data  = data_q[7];
  assign port8_rd_data  = data_q[8];

  assign port0_rd_valid = valid_q[0];
  assign port1_rd_valid = valid_q[1];
  assign port2_rd_valid = valid_q[2];
  assign port3_rd_valid = valid_q[3];
  assign port4_rd_valid = valid_q[4];
  assign port5_rd_valid = valid_q[5];
  assign port6_rd_valid = valid_q[6];
  assign port7_rd_valid = valid_q[7];
  assign port8_rd_valid = valid_q[8];

endmodule

// File: tb/tb_rd_return_1_to_9.sv
// Scoreboard bench for rd_return_1_to_9: driver queues expected returns, monitor checks them
// along with held data, the one-hot valid rule and multi_rd_err.
module tb_rd_return_1_to_9;

  localparam int WIDTH = 32;
  localparam int LAT   = 3;

  logic             clk;
  logic             rst;
  logic [8:0]       en;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] od [9];
  logic [8:0]       vld;
  logic             multi_rd_err;

  typedef struct {
    int               port;
    logic [WIDTH-1:0] data;
    int               cyc;
    bit               kill;
  } exp_t;

  exp_t             q[$];
  logic [WIDTH-1:0] rd_sched [int];
  int               cyc;
  int               rd_ptr;
  int               checks;
  int               errors;
  logic [WIDTH-1:0] model [9];
  bit               rst_seen;
  logic             err_exp;

  rd_return_1_to_9 #(.WIDTH(WIDTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .port0_rd_en(en[0]), .port1_rd_en(en[1]), .port2_rd_en(en[2]),
    .port3_rd_en(en[3]), .port4_rd_en(en[4]), .port5_rd_en(en[5]),
    .port6_rd_en(en[6]), .port7_rd_en(en[7]), .port8_rd_en(en[8]),
    .rd_data(rd_data),
    .port0_rd_data(od[0]), .port1_rd_data(od[1]), .port2_rd_data(od[2]),
    .port3_rd_data(od[3]), .port4_rd_data(od[4]), .port5_rd_data(od[5]),
    .port6_rd_data(od[6]), .port7_rd_data(od[7]), .port8_rd_data(od[8]),
    .port0_rd_valid(vld[0]), .port1_rd_valid(vld[1]), .port2_rd_valid(vld[2]),
    .port3_rd_valid(vld[3]), .port4_rd_valid(vld[4]), .port5_rd_valid(vld[5]),
    .port6_rd_valid(vld[6]), .port7_rd_valid(vld[7]), .port8_rd_valid(vld[8]),
    .multi_rd_err(multi_rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus; rd_data follows the return schedule, random otherwise
  task automatic step(input logic [8:0] e, input logic r);
    en  = e;
    rst = r;
    if (rd_sched.exists(cyc)) rd_data = rd_sched[cyc];
    else rd_data = $urandom();
    if (r) begin
      for (int i = 0; i < q.size(); i++)
        if (q[i].cyc >= cyc + 1) q[i].kill = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic req(input int p, input logic [WIDTH-1:0] d);
    exp_t e;
    logic [8:0] onehot;
    onehot = 9'd1 << p;
    rd_sched[cyc + LAT] = d;
    e.port = p;
    e.data = d;
    e.cyc  = cyc + LAT + 1;
    e.kill = 1'b0;
    q.push_back(e);
    step(onehot, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(9'd0, 1'b0);
  endtask

  always @(posedge clk) begin
    rst_seen = rst;
    if (rst) err_exp = 1'b0;
`ifdef RD_RETURN_MULTI_ERR_EN
    else if ($countones(en) > 1) err_exp = 1'b1;
`endif
  end

  always @(negedge clk) begin
    exp_t e;
    bit   bad;
    if (rst_seen) begin
      for (int p = 0; p < 9; p++) model[p] = '0;
    end

    checks++;
    if (multi_rd_err !== err_exp) begin
      errors++;
      $display("FAIL multi_rd_err cyc=%0d got=%b exp=%b", cyc, multi_rd_err, err_exp);
    end

    while (rd_ptr < q.size() && (q[rd_ptr].kill || q[rd_ptr].cyc < cyc)) begin
      if (!q[rd_ptr].kill) begin
        checks++;
        errors++;
        $display("FAIL missing_valid cyc=%0d got=none exp=port%0d@%0d", cyc, q[rd_ptr].port, q[rd_ptr].cyc);
      end
      rd_ptr++;
    end

    bad = 1'b0;
    for (int p = 0; p < 9; p++)
      if (vld[p] !== 1'b1 && od[p] !== model[p]) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL data_hold cyc=%0d got=%h/%h/%h exp=%h/%h/%h", cyc, od[0], od[3], od[8],
               model[0], model[3], model[8]);
    end

    if (vld !== 9'd0) begin
      checks++;
      if (!$onehot(vld)) begin
        errors++;
        $display("FAIL valid_onehot cyc=%0d got=%b exp=onehot", cyc, vld);
      end
      if (rd_ptr < q.size() && q[rd_ptr].cyc == cyc) begin
        e = q[rd_ptr];
        rd_ptr++;
        checks++;
        if (vld !== (9'd1 << e.port)) begin
          errors++;
          $display("FAIL valid_port cyc=%0d got=%b exp=%b", cyc, vld, 9'd1 << e.port);
        end
        checks++;
        if (od[e.port] !== e.data) begin
          errors++;
          $display("FAIL rd_data port%0d cyc=%0d got=%h exp=%h", e.port, cyc, od[e.port], e.data);
        end
        model[e.port] = e.data;
      end else begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid cyc=%0d got=%b exp=000000000", cyc, vld);
      end
    end
  end

  initial begin
    cyc     = 0;
    rd_ptr  = 0;
    checks  = 0;
    errors  = 0;
    err_exp = 1'b0;
    en      = '0;
    rst     = 1'b1;
    rd_data = '0;
    for (int p = 0; p < 9; p++) model[p] = '0;

    step(9'd0, 1'b1);
    step(9'd0, 1'b1);
    step(9'd0, 1'b1);
    idle(4);

    req(3, 32'hDEADBEEF);
    idle(LAT + 3);

    req(0, 32'd1);
    req(8, 32'd2);
    req(0, 32'd3);
    idle(LAT + 3);

    idle(20);

    step(9'b000100100, 1'b0);
    idle(LAT + 3);

    for (int n = 0; n < 9; n++) req(n, 32'h100 + n);
    idle(LAT + 3);

    req(6, 32'h0000_0066);
    step(9'd0, 1'b1);
    idle(1);
    req(1, 32'h0000_0011);
    idle(LAT + 3);

    req(7, 32'hCAFE_0007);
    step(9'b110000000, 1'b0);
    req(2, 32'h1234_5678);
    idle(LAT + 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rd_return_1_to_9.md
Name: rd_return_1_to_9

Overview:
- Return path for a 9-requester shared register-file read port.
- Samples the same one-hot portN_rd_en set that steers the shared read address.
- Pipelines the requester identity for the register file's read latency.
- Routes the returned rd_data to the requesting port with a one-cycle valid strobe.
- Sits between the register-file read data output and the nine consuming units (ALUs / LSU / SALU operand collectors).

Parameters:
- WIDTH, 32, read data width in bits.
- LATENCY, 1, cycles from request (portN_rd_en high) to rd_data valid at the register-file output; legal range 1..4.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- portN_rd_en  input  1  read request from port N, N=0..8 (nine ports); same cycle as the address to the register file
- rd_data  input  WIDTH  register-file read data; corresponds to the request issued LATENCY cycles earlier
- portN_rd_data  output  WIDTH  returned data for port N, N=0..8
- portN_rd_valid  output  1  one-cycle strobe: portN_rd_data holds data for port N's request, N=0..8
- multi_rd_err  output  1  sticky flag: more than one portN_rd_en was seen high in the same cycle

Behaviour:
- Reset: one clock; reset is synchronous and active-high (clk, rst). While rst=1 at a clk edge:
  - tag pipeline cleared (all stage valids 0);
  - all portN_rd_valid=0;
  - all portN_rd_data=0;
  - multi_rd_err=0.
- Request decode, each cycle, from the 9-bit vector {port8_rd_en..port0_rd_en}:
  - exactly one bit set -> tag = {valid=1, idx=4-bit port index}.
  - zero bits set -> tag valid=0.
  - two or more bits set -> tag valid=0 (request dropped; no port receives a valid) and the error condition is raised.
- Tag pipeline:
  - LATENCY stages of {valid, idx[3:0]}; a new tag enters every cycle.
  - Throughput is 1 request/cycle; back-to-back requests from the same or different ports are supported.
- Return:
  - When the last stage tag is valid, on the next clk edge: port[idx]_rd_data <= rd_data and port[idx]_rd_valid <= 1.
  - All other portN_rd_valid <= 0.
  - Total latency: request in cycle T -> portN_rd_valid=1 in cycle T+LATENCY+1, for exactly one cycle.
- Data hold:
  - portN_rd_data changes only when port N is the returned index; otherwise it holds its previous value.
  - portN_rd_data is not cleared when valid drops.
- At most one portN_rd_valid is high in any cycle.
- Reset mid-operation: in-flight tags are discarded. No valid is produced for requests issued before or during reset, including the cycle rst deasserts. A request in the first cycle after rst=0 returns normally.
- No backpressure: consumers must accept data in the valid cycle.
- rd_data is ignored when the last stage tag is invalid.
- idx values 9..15 cannot occur; the decode must not generate them.

Optional Feature:
- Macro: RD_RETURN_MULTI_ERR_EN.
- Defined:
  - multi_rd_err sets on any cycle with two or more portN_rd_en high (registered, visible next cycle).
  - It stays 1 until rst.
  - Dropped-request behaviour is unchanged.
- Undefined:
  - multi_rd_err is tied to 0 and no detection logic is built.
  - Multi-enable cycles still drop the request (tag valid=0).

Test Plan:
- Single return, LATENCY=1: port3_rd_en=1 in cycle 10; rd_data=32'hDEADBEEF in cycle 11 -> cycle 12: port3_rd_valid=1, port3_rd_data=32'hDEADBEEF; all other valids 0. Cycle 13: port3_rd_valid=0, port3_rd_data still 32'hDEADBEEF.
- Back-to-back, LATENCY=2: port0 in cycle 5, port8 in cycle 6, port0 in cycle 7; rd_data=1, 2, 3 in cycles 7, 8, 9 -> port0 valid with 1 in cycle 8, port8 valid with 2 in cycle 9, port0 valid with 3 in cycle 10.
- Idle: no enables for 20 cycles while rd_data toggles random values -> no valid ever asserts; all portN_rd_data unchanged.
- Collision: port2_rd_en=port5_rd_en=1 in cycle 4 -> no valid in cycle 4+LATENCY+1. With RD_RETURN_MULTI_ERR_EN: multi_rd_err=1 from cycle 5 until rst. Without the macro: multi_rd_err stays 0.
- Reset mid-flight, LATENCY=3: port6 request in cycle 20, rst=1 in cycle 21 -> port6_rd_valid never asserts; all outputs 0 after reset. port1 request in cycle 23 (after rst=0) -> port1_rd_valid in cycle 27.
- Sweep: each port N=0..8 requests once with rd_data=N+32'h100 -> port N alone strobes with data N+32'h100 at T+LATENCY+1.
